// File: rtl/pingpang_pkg.sv
// Shared types and width helpers for the ping-pong stream buffer.
// Bank occupancy states and the address/length sizing used by every bank.
package pingpang_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  // Address width for DEPTH words; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Length width: must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int len_w(input int depth);
    return (depth > 1) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/pingpang_bank.sv
// One bank of the ping-pong buffer: storage, EMPTY/FULL state and committed length.
// Commit and release never target the same bank in one cycle (they need opposite states).
module pingpang_bank
  import pingpang_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = addr_w(DEPTH),
  localparam int LW = len_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  input  logic [LW-1:0]    commit_len,
  input  logic             rel,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic [LW-1:0]    len
);

  logic [WIDTH-1:0] mem [DEPTH];
  bank_state_t      state;

  // Storage is deliberately left out of reset; the state flag alone gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      len   <= '0;
    end else if (commit) begin
      state <= FULL;
      len   <= commit_len;
    end else if (rel) begin
      state <= EMPTY;
    end
  end

  always_comb begin
    rd_data = mem[rd_addr];
    full    = (state == FULL);
  end

endmodule

// File: rtl/pingpang_stream_buffer.sv
// Two-bank ping-pong stream buffer: one bank fills while the other drains.
// Banks commit on DEPTH words or in_last and are drained strictly alternately from bank 0.
module pingpang_stream_buffer
  import pingpang_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             wr_bank,
  output logic             rd_bank,
  output logic [1:0]       bank_full
);

  localparam int AW = addr_w(DEPTH);
  localparam int LW = len_w(DEPTH);

  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [1:0]       full_w;
  logic [LW-1:0]    bank_len [2];
  logic [WIDTH-1:0] bank_rd_data [2];
  logic [LW-1:0]    rd_len;
  logic [LW-1:0]    commit_len;
  logic             in_acc;
  logic             out_acc;
  logic             commit_now;
  logic             release_now;

  // Handshake decode depends only on registered state, never on the opposite side's inputs.
  always_comb begin
    in_ready    = ~full_w[wr_bank];
    out_valid   = full_w[rd_bank];
    rd_len      = bank_len[rd_bank];
    out_last    = out_valid && (LW'(rd_addr) == (rd_len - LW'(1)));
    out_data    = out_valid ? bank_rd_data[rd_bank] : '0;
    in_acc      = in_valid && in_ready;
    out_acc     = out_valid && out_ready;
    commit_now  = in_acc && ((wr_addr == AW'(DEPTH - 1)) || in_last);
    commit_len  = LW'(wr_addr) + LW'(1);
    release_now = out_acc && out_last;
    bank_full   = full_w;
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    pingpang_bank #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (in_acc && (wr_bank == 1'(g))),
      .wr_addr   (wr_addr),
      .wr_data   (in_data),
      .commit    (commit_now && (wr_bank == 1'(g))),
      .commit_len(commit_len),
      .rel       (release_now && (rd_bank == 1'(g))),
      .rd_addr   (rd_addr),
      .rd_data   (bank_rd_data[g]),
      .full      (full_w[g]),
      .len       (bank_len[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else if (in_acc) begin
      if (commit_now) begin
        wr_bank <= ~wr_bank;
        wr_addr <= '0;
      end else begin
        wr_addr <= wr_addr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      rd_addr <= '0;
    end else if (out_acc) begin
      if (out_last) begin
        rd_bank <= ~rd_bank;
        rd_addr <= '0;
      end else begin
        rd_addr <= rd_addr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pingpang_stream_buffer.sv
// Directed table-driven bench for pingpang_stream_buffer (WIDTH=16, DEPTH=4).
// Each row: inputs driven for one cycle and the outputs expected before that cycle's rising edge.
module tb_pingpang_stream_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        wr_bank;
  logic        rd_bank;
  logic [1:0]  bank_full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        il;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [15:0] od;
    logic        ol;
    logic [1:0]  bf;
    logic        wb;
    logic        rb;
  } vec_t;

  vec_t tbl[$];
  vec_t tail[$];

  pingpang_stream_buffer #(.WIDTH(16), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .wr_bank  (wr_bank),
    .rd_bank  (rd_bank),
    .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic iv, input logic [15:0] id, input logic il,
                              input logic ordy, input logic ir, input logic ov,
                              input logic [15:0] od, input logic ol, input logic [1:0] bf,
                              input logic wb, input logic rb);
    vec_t v;
    v.iv = iv; v.id = id; v.il = il; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.ol = ol; v.bf = bf; v.wb = wb; v.rb = rb;
    return v;
  endfunction

  task automatic check_now(input vec_t v, input string name);
    checks++;
    if (in_ready !== v.ir || out_valid !== v.ov || out_data !== v.od || out_last !== v.ol ||
        bank_full !== v.bf || wr_bank !== v.wb || rd_bank !== v.rb) begin
      errors++;
      $display("FAIL %s: got ir=%0b ov=%0b od=%0d ol=%0b bf=%b wb=%0b rb=%0b, exp ir=%0b ov=%0b od=%0d ol=%0b bf=%b wb=%0b rb=%0b",
               name, in_ready, out_valid, out_data, out_last, bank_full, wr_bank, rd_bank,
               v.ir, v.ov, v.od, v.ol, v.bf, v.wb, v.rb);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    in_valid  = v.iv;
    in_data   = v.id;
    in_last   = v.il;
    out_ready = v.ordy;
    #1;
    check_now(v, name);
  endtask

  initial begin
    vec_t rst_exp;
    rst_exp = mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    rst_n = 1'b0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;

    // Full-bank fill, both banks full, continuous drain.
    for (int d = 10; d <= 40; d += 10) tbl.push_back(mk(1, 16'(d), 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    for (int d = 50; d <= 80; d += 10) tbl.push_back(mk(1, 16'(d), 0, 0, 1, 1, 10, 0, 2'b01, 1, 0));
    tbl.push_back(mk(1, 99, 0, 0, 0, 1, 10, 0, 2'b11, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 10, 0, 2'b11, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 20, 0, 2'b11, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 30, 0, 2'b11, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 40, 1, 2'b11, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 50, 0, 2'b10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 60, 0, 2'b10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 70, 0, 2'b10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 80, 1, 2'b10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0));
    // Early commit with in_last: two-word bank.
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 2'b01, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 2, 1, 2'b01, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 1));
    // Length-1 bank, then release of bank 0 coinciding with commit of bank 1.
    tbl.push_back(mk(1, 3, 1, 0, 1, 0, 0, 0, 2'b00, 1, 1));
    tbl.push_back(mk(1, 4, 0, 1, 1, 1, 3, 1, 2'b10, 0, 1));
    tbl.push_back(mk(1, 5, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 6, 0, 1, 1, 1, 4, 0, 2'b01, 1, 0));
    tbl.push_back(mk(1, 7, 1, 1, 1, 1, 5, 1, 2'b01, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 6, 0, 2'b10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 6, 0, 2'b10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 7, 1, 2'b10, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    // Partial drain before the mid-drain reset.
    for (int d = 11; d <= 14; d++) tbl.push_back(mk(1, 16'(d), 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 11, 0, 2'b01, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 12, 0, 2'b01, 1, 0));
    // After reset: 5,6,7,8 through bank 0.
    for (int d = 5; d <= 8; d++) tail.push_back(mk(1, 16'(d), 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    for (int d = 5; d <= 8; d++) tail.push_back(mk(0, 0, 0, 1, 1, 1, 16'(d), (d == 8), 2'b01, 1, 0));
    tail.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 1));

    @(negedge clk);
    check_now(rst_exp, "reset_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-drain: outputs must clear without waiting for a clock edge.
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    #2 rst_n = 1'b0;
    #1 check_now(rst_exp, "reset_async");
    @(negedge clk);
    check_now(rst_exp, "reset_held");
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 0;

    for (int i = 0; i < tail.size(); i++) apply(tail[i], $sformatf("post_rst%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pingpang_stream_buffer.md
PINGPANG_STREAM_BUFFER -- requirements
Module: pingpang_stream_buffer

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, words per bank (>=2, need not be a power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 in_valid  input  1  write-side word present.
REQ-006 in_ready  output  1  write bank can accept a word.
REQ-007 in_data  input  WIDTH  write-side word.
REQ-008 in_last  input  1  close the current bank after this word (early commit).
REQ-009 out_valid  output  1  read-side word present.
REQ-010 out_ready  input  1  consumer accepts the word.
REQ-011 out_data  output  WIDTH  read-side word.
REQ-012 out_last  output  1  final word of the bank being drained.
REQ-013 wr_bank  output  1  index of the bank currently being filled.
REQ-014 rd_bank  output  1  index of the bank currently being drained.
REQ-015 bank_full  output  2  per-bank committed flag, bit i for bank i.

Function
REQ-016 Two banks of DEPTH x WIDTH storage; each bank has state EMPTY (fillable) or FULL (committed, holding a length 1..DEPTH).
REQ-017 Write accept = in_valid && in_ready; in_ready = (bank[wr_bank] is EMPTY), combinational from state only.
REQ-018 On accept, in_data is stored at wr_addr of bank[wr_bank] and wr_addr increments.
REQ-019 The accepting edge commits the bank when wr_addr == DEPTH-1 or in_last == 1: bank goes FULL with length wr_addr+1, wr_bank toggles, wr_addr returns to 0.
REQ-020 in_last on the first word of a bank yields a length-1 bank.
REQ-021 out_valid = (bank[rd_bank] is FULL); out_data = word at rd_addr of bank[rd_bank] when out_valid, else 0.
REQ-022 out_last = out_valid && (rd_addr == length-1).
REQ-023 Read accept = out_valid && out_ready; increments rd_addr; on accept with out_last the bank returns EMPTY, rd_bank toggles, rd_addr returns to 0.
REQ-024 Latency: a committed bank presents its first word on out_valid in the cycle after the committing edge; no bypass of uncommitted words.
REQ-025 When both banks are FULL, in_ready = 0 and in_data is ignored; no word is lost or overwritten.
REQ-026 Simultaneous commit of one bank and release of the other in the same cycle both take effect; in_ready reflects the newly released bank in the next cycle.
REQ-027 Word order is preserved across banks; banks are drained strictly alternately starting from bank 0.
REQ-028 Counter widths: wr_addr/rd_addr $clog2(DEPTH) bits; length $clog2(DEPTH+1) bits; no wrap beyond DEPTH-1.

Reset
REQ-029 While rst_n = 0: both banks EMPTY, wr_bank = rd_bank = 0, addresses 0, in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, bank_full = 2'b00.
REQ-030 Reset asserted mid-fill or mid-drain discards all buffered words; storage contents need not be cleared.
REQ-031 After rst_n deasserts, the first accept may occur on the first rising edge.

Structure
REQ-032 Shared package pingpang_pkg holds bank_state_t (EMPTY, FULL) and length/address width helper functions.
REQ-033 Sub-module pingpang_bank (storage, state, length; write port, read port, commit, release) instantiated twice; top holds wr_bank/rd_bank selection and addresses.

Verification (WIDTH=16, DEPTH=4)
REQ-034 Reset: rst_n=0 -> in_ready=1, out_valid=0, out_data=0, out_last=0, bank_full=00, wr_bank=rd_bank=0.
REQ-035 Write 10,20,30,40 with out_ready=0 -> bank_full=01 and out_valid=1, out_data=10 the cycle after 4th accept; write 50,60,70,80 -> bank_full=11, in_ready=0.
REQ-036 Then out_ready=1 continuously -> out_data 10,20,30,40,50,60,70,80 on consecutive cycles, out_last on 40 and 80, in_ready=1 the cycle after 40 is accepted.
REQ-037 Write 1,2 with in_last on 2 -> 2-word bank; output 1,2 with out_last on 2; next write lands in bank 1.
REQ-038 Bank 0 FULL, bank 1 filling: final accept of bank 0 read coincides with commit of bank 1 -> bank_full=10, rd_bank=1, wr_bank=0, in_ready=1 next cycle.
REQ-039 Assert rst_n=0 after 2 of 4 words drained -> REQ-029 values immediately; subsequent writes 5,6,7,8 output as 5,6,7,8 from bank 0.
